// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Scoreboard entries hold register addresses zero-extended to this width
  localparam int MAX_SEL_BITS      = 8;
  localparam int BR_RESOLVE_CYCLES = 2;
  localparam int BR_CNT_W          = $clog2(BR_RESOLVE_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                    valid;
    logic [MAX_SEL_BITS-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_controller_write_scoreboard.sv
// rtl/hazard_controller_write_scoreboard.sv - in-flight destination shift register with RAW match
module write_scoreboard
  import hazard_pkg::*;
#(
  parameter int pipeDepth = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  sb_entry_t               shift_in,
  input  logic [MAX_SEL_BITS-1:0] query1,
  input  logic                    use1,
  input  logic [MAX_SEL_BITS-1:0] query2,
  input  logic                    use2,
  output logic                    match
);

  sb_entry_t sb_q [pipeDepth];
  sb_entry_t sb_d [pipeDepth];

  always_comb begin
    sb_d[0] = shift_in;
    for (int i = 1; i < pipeDepth; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < pipeDepth; i++) sb_q[i] <= '0;
    end else begin
      for (int i = 0; i < pipeDepth; i++) sb_q[i] <= sb_d[i];
    end
  end

  // No forwarding: any in-flight writer of a read source is a hazard until it commits
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < pipeDepth; i++) begin
      if (sb_q[i].valid && ((use1 && (sb_q[i].rd == query1)) ||
                            (use2 && (sb_q[i].rd == query2)))) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW/branch sequencing for the 4-stage vector ASIP pipeline
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int selectionBits = 4,
  parameter int pipeDepth     = 3,
  parameter int cntWidth      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [selectionBits-1:0] dec_rsel1,
  input  logic [selectionBits-1:0] dec_rsel2,
  input  logic                     dec_use1,
  input  logic                     dec_use2,
  input  logic                     dec_wr,
  input  logic [selectionBits-1:0] dec_rd,
  input  logic                     dec_branch,
  input  logic                     mem_pc_wr,
  output logic                     stall_f,
  output logic                     bubble_de,
  output logic                     flush_fd,
  output logic                     flush_de,
  output logic [1:0]               state,
  output logic [cntWidth-1:0]      stall_cycles,
  output logic [cntWidth-1:0]      flush_count
);

  hz_state_e             state_q, state_d;
  logic [BR_CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [cntWidth-1:0]   stall_cycles_q, stall_cycles_d;
  logic [cntWidth-1:0]   flush_count_q, flush_count_d;
  logic                  raw;
  logic                  issue;
  sb_entry_t             sb_in;

  // FLUSH never issues, so entry 0 is loaded empty during the flush cycle
  assign issue       = dec_valid & ~stall_f & ~bubble_de & (state_q == RUN);
  assign sb_in.valid = issue & dec_wr;
  assign sb_in.rd    = MAX_SEL_BITS'(dec_rd);

  write_scoreboard #(.pipeDepth(pipeDepth)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst),
    .shift_in (sb_in),
    .query1   (MAX_SEL_BITS'(dec_rsel1)),
    .use1     (dec_use1),
    .query2   (MAX_SEL_BITS'(dec_rsel2)),
    .use2     (dec_use2),
    .match    (raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      br_cnt_q       <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      br_cnt_q       <= br_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // A hazard holds the branch in decode; it only issues once raw clears
  always_comb begin
    state_d  = state_q;
    br_cnt_d = br_cnt_q;
    case (state_q)
      RUN: begin
        if (!raw && dec_valid && dec_branch) begin
          state_d  = BR_WAIT;
          br_cnt_d = BR_CNT_W'(BR_RESOLVE_CYCLES);
        end
      end
      BR_WAIT: begin
        br_cnt_d = br_cnt_q - BR_CNT_W'(1);
        if (mem_pc_wr) begin
          state_d = FLUSH;
        end else if (br_cnt_q <= BR_CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_f   = 1'b0;
    bubble_de = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    case (state_q)
      RUN: begin
        stall_f   = raw;
        bubble_de = raw;
      end
      BR_WAIT: begin
        stall_f   = 1'b1;
        bubble_de = 1'b1;
      end
      FLUSH: begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_f && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + cntWidth'(1);
    end
    if ((state_q == FLUSH) && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + cntWidth'(1);
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed checks against a cycle-indexed reference model
module tb_hazard_controller;

  localparam int SB = 4;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid, dec_use1, dec_use2, dec_wr, dec_branch, mem_pc_wr;
  logic [SB-1:0] dec_rsel1, dec_rsel2, dec_rd;
  logic          stall_f, bubble_de, flush_fd, flush_de;
  logic [1:0]    state;
  logic [15:0]   stall_cycles, flush_count;
  logic          stall_f4, bubble_de4, flush_fd4, flush_de4;
  logic [1:0]    state4;
  logic [3:0]    stall_cycles4, flush_count4;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rsel1(dec_rsel1), .dec_rsel2(dec_rsel2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_wr(dec_wr), .dec_rd(dec_rd),
    .dec_branch(dec_branch), .mem_pc_wr(mem_pc_wr), .stall_f(stall_f), .bubble_de(bubble_de),
    .flush_fd(flush_fd), .flush_de(flush_de), .state(state), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  hazard_controller #(.cntWidth(4)) dut4 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rsel1(dec_rsel1), .dec_rsel2(dec_rsel2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_wr(dec_wr), .dec_rd(dec_rd),
    .dec_branch(dec_branch), .mem_pc_wr(mem_pc_wr), .stall_f(stall_f4), .bubble_de(bubble_de4),
    .flush_fd(flush_fd4), .flush_de(flush_de4), .state(state4), .stall_cycles(stall_cycles4),
    .flush_count(flush_count4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-register issue cycle of the latest write, plus branch mode
  int last_wr [16];
  int cyc;
  int mode;      // 0 running, 1 waiting on branch, 2 flushing
  int wait_n;
  int m_stalls;
  int m_flushes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit pending(input int r);
    int age;
    age = cyc - last_wr[r];
    return (age >= 1) && (age <= DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) last_wr[i] = -100;
    cyc = 0; mode = 0; wait_n = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input bit wr, input int rd, input bit br, input bit pcwr);
    dec_valid = v; dec_rsel1 = SB'(r1); dec_use1 = u1; dec_rsel2 = SB'(r2); dec_use2 = u2;
    dec_wr = wr; dec_rd = SB'(rd); dec_branch = br; mem_pc_wr = pcwr;
  endtask

  // Called 1 time unit after a rising edge; leaves the bench 1 unit after the next one
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_stall_f", stall_f, 0);
    check("rst_bubble_de", bubble_de, 0);
    check("rst_flush_fd", flush_fd, 0);
    check("rst_flush_de", flush_de, 0);
    check("rst_state", state, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_flush_count", flush_count, 0);
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit raw, issue;
    int e_stall, e_flush, e_state;
    raw = (dec_use1 && pending(int'(dec_rsel1))) || (dec_use2 && pending(int'(dec_rsel2)));
    e_stall = (mode == 1) || (mode == 0 && raw);
    e_flush = (mode == 2);
    e_state = mode;
    #3;
    check("stall_f", stall_f, e_stall);
    check("bubble_de", bubble_de, e_stall);
    check("flush_fd", flush_fd, e_flush);
    check("flush_de", flush_de, e_flush);
    check("state", state, e_state);
    check("stall_cycles", stall_cycles, sat(m_stalls, 65535));
    check("flush_count", flush_count, sat(m_flushes, 65535));
    check("stall_f_w4", stall_f4, e_stall);
    check("state_w4", state4, e_state);
    check("stall_cycles_w4", stall_cycles4, sat(m_stalls, 15));
    check("flush_count_w4", flush_count4, sat(m_flushes, 15));
    issue = (mode == 0) && dec_valid && !raw;
    if (issue && dec_wr) last_wr[int'(dec_rd)] = cyc;
    m_stalls += e_stall;
    case (mode)
      0: if (issue && dec_branch) begin mode = 1; wait_n = 0; end
      1: begin
        wait_n++;
        if (mem_pc_wr) mode = 2;
        else if (wait_n == 2) mode = 0;
      end
      default: begin mode = 0; m_flushes++; end
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk);
    #1;

    // Back-to-back dependency on r3
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    step();
    check("b2b_stall_cycles", stall_cycles, 3);

    // Independent stream
    do_reset();
    drive(1, 5, 1, 6, 1, 1, 1, 0, 0); step();
    drive(1, 5, 1, 6, 1, 1, 2, 0, 0); step();
    drive(1, 6, 1, 5, 1, 1, 4, 0, 0); step();
    drive(1, 5, 1, 6, 1, 0, 0, 0, 0); step();
    check("indep_stall_cycles", stall_cycles, 0);

    // Taken branch resolving on the second wait cycle
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step();
    idle(); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); step();
    check("taken_flush_count", flush_count, 1);
    check("taken_state", state, 0);
    check("taken_stall_cycles", stall_cycles, 2);

    // Not-taken branch
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step();
    idle(); step();
    step();
    check("ntaken_state", state, 0);
    check("ntaken_flush_count", flush_count, 0);
    check("ntaken_stall_cycles", stall_cycles, 2);

    // Saturation of the narrow counter after 20+ stall cycles
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step();
      idle(); step(); step();
    end
    check("sat_stall_w4", stall_cycles4, 15);
    check("sat_stall_w16", stall_cycles, 22);

    // Reset while waiting on a branch drops the pending r9 write
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step();
    idle();
    check("brwait_entered", state, 1);
    do_reset();
    drive(1, 9, 1, 9, 1, 0, 0, 0, 0);
    #1;
    check("post_rst_no_stall", stall_f, 0);
    #1;
    step();

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 9) < 6),
            $urandom_range(0, 7), ($urandom_range(0, 9) == 0), $urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 4-stage vector ASIP: fetch, decode, execute, memory/write-back, plus a commit register into the register file.
- Detects read-after-write hazards on decode, holds branches until they resolve in the memory stage, and emits stall, bubble and flush strobes to the inter-stage pipes and the PC.
- Keeps saturating stall and flush statistics counters.

Parameters:
- selectionBits, 4, register address width (rSel1, rSel2, RegToWrite).
- pipeDepth, 3, entries in the in-flight write scoreboard: EX, MEM, commit.
- cntWidth, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_rsel1  in  selectionBits  source register 1.
- dec_rsel2  in  selectionBits  source register 2.
- dec_use1  in  1  source 1 is read.
- dec_use2  in  1  source 2 is read.
- dec_wr  in  1  instruction writes a register (RegWriteEnSc or RegWriteEnVec).
- dec_rd  in  selectionBits  destination register.
- dec_branch  in  1  PcWriteEn non-zero in decode.
- mem_pc_wr  in  1  branch taken, asserted in the memory stage.
- stall_f  out  1  hold the PC and the fetch/decode pipe.
- bubble_de  out  1  load a NOP into the decode/execute pipe.
- flush_fd  out  1  clear the fetch/decode pipe.
- flush_de  out  1  clear the decode/execute pipe.
- state  out  2  FSM state, for debug.
- stall_cycles  out  cntWidth  saturating count of stall cycles.
- flush_count  out  cntWidth  saturating count of taken-branch flushes.

Behaviour:
- Reset, asynchronous while rst=0:
  - state=RUN, scoreboard cleared, counters 0.
  - All strobe outputs 0.
- Scoreboard:
  - pipeDepth entries, each {valid, rd}, shifting one stage per clk.
  - Entry 0 loads {issue & dec_wr, dec_rd}.
  - issue = dec_valid & ~stall_f & ~bubble_de & state==RUN.
  - The last entry falls off after the commit cycle.
- RAW hazard (combinational):
  - raw = any valid entry with rd==dec_rsel1 & dec_use1, or rd==dec_rsel2 & dec_use2.
  - No forwarding exists.
  - A destination match is scalar/vector agnostic (conservative).
- FSM states: RUN=0, BR_WAIT=1, FLUSH=2.
- RUN:
  - raw=1: stall_f=1, bubble_de=1, same cycle.
  - raw=0 & dec_valid & dec_branch: the branch issues, state goes to BR_WAIT, and br_cnt loads 2.
- BR_WAIT:
  - stall_f=1, bubble_de=1.
  - br_cnt decrements each cycle.
  - mem_pc_wr=1: state goes to FLUSH.
  - br_cnt reaches 0 without mem_pc_wr: branch not taken, state returns to RUN.
- FLUSH (exactly one cycle):
  - flush_fd=1, flush_de=1, stall_f=0 so the redirected PC fetches.
  - Scoreboard entry 0 is cleared.
  - flush_count increments.
  - Next state is RUN.
- Priority:
  - mem_pc_wr in any state other than BR_WAIT is ignored; a branch is always tracked through BR_WAIT.
  - A raw hazard and a branch in the same cycle: stall on the hazard first. The branch issues only once raw clears.
- Statistics:
  - stall_cycles increments in every cycle with stall_f=1.
  - Both counters saturate at all-ones and never wrap.
- Reset mid-operation: any state returns to RUN, in-flight entries are discarded, and no flush is emitted.
- Latency: stall and flush outputs are combinational from the registered state and the current decode inputs; there is no added pipeline delay.

Decomposition:
- Shared package hazard_pkg:
  - FSM state enum {RUN, BR_WAIT, FLUSH}.
  - Scoreboard entry struct {valid, rd}.
  - Constant BR_RESOLVE_CYCLES=2.
- One natural sub-module, write_scoreboard: the shift register plus match logic. Ports: shift-in entry, two source queries, match out.

Test Plan:
- Back-to-back dependency:
  - Stimulus: issue r3 write, then the next instruction reads r3 (dec_use1=1, dec_rsel1=3).
  - Required: stall_f and bubble_de high for 3 cycles, then issue; stall_cycles=3.
- Independent stream:
  - Stimulus: writes to r1, r2, r4 and reads of r5, r6.
  - Required: no stall; stall_cycles stays 0.
- Taken branch:
  - Stimulus: dec_branch issued; mem_pc_wr=1 on the 2nd BR_WAIT cycle.
  - Required: stall for 2 cycles, then one FLUSH cycle with flush_fd=flush_de=1; flush_count=1; state returns to RUN.
- Not-taken branch:
  - Stimulus: mem_pc_wr held 0.
  - Required: 2 stall cycles, no flush, RUN resumes, flush_count=0.
- Saturation:
  - Stimulus: preload, or run with cntWidth=4 and 20 stall cycles.
  - Required: stall_cycles=15 and holds.
- Reset in BR_WAIT:
  - Stimulus: drive rst=0 mid-wait.
  - Required: outputs 0 immediately (asynchronous), state=RUN, scoreboard empty; the next read of a previously pending rd does not stall.
